// File: rtl/game_sequencer.sv
// Game sequencer for a two-player ball game: IDLE -> SERVE -> PLAY -> POINT/OVER.
// All events are qualified by rising-edge pulses of frame_tick and start; all
// outputs are registered, so an event shows up at the same clk edge that samples it.
// Optional build macro: GAME_SEQ_ALT_SERVE_EN (alternate serve direction on each
// re-serve instead of serving toward the player who conceded).
module game_sequencer #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic       ball_run,
  output logic       ball_load,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [2:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_e;

  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [7:0] SF  = 8'(SERVE_FRAMES);
  localparam logic [7:0] PF  = 8'(POINT_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic [2:0] win_q, win_d;
  logic       run_q, run_d, load_q, load_d, sdir_q, sdir_d;
  logic       tick_q, start_q;
  logic       tick, start_p;
  logic [3:0] p1_inc, p2_inc;

  assign tick    = frame_tick & ~tick_q;
  assign start_p = start & ~start_q;
  // Saturating increments; WIN_SCORE <= 15 normally ends the game first.
  assign p1_inc  = (p1_q == 4'hF) ? 4'hF : p1_q + 4'd1;
  assign p2_inc  = (p2_q == 4'hF) ? 4'hF : p2_q + 4'd1;

  // State, counter, score and output registers with async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      win_q   <= '0;
      run_q   <= 1'b0;
      load_q  <= 1'b0;
      sdir_q  <= 1'b0;
      tick_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      win_q   <= win_d;
      run_q   <= run_d;
      load_q  <= load_d;
      sdir_q  <= sdir_d;
      tick_q  <= frame_tick;
      start_q <= start;
    end
  end

  // Next-state logic; start_p is only honoured in IDLE/OVER, where it also
  // swallows any coincident tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    run_d   = run_q;
    load_d  = 1'b0;
    sdir_d  = sdir_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_p) begin
          state_d = SERVE;
          p1_d    = '0;
          p2_d    = '0;
          win_d   = '0;
          run_d   = 1'b0;
          load_d  = 1'b1;
          sdir_d  = 1'b0;
          cnt_d   = SF;
        end
      end
      SERVE: begin
        if (tick) begin
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          else begin
            state_d = PLAY;
            run_d   = 1'b1;
          end
        end
      end
      PLAY: begin
        // Simultaneous goals are treated as no score.
        if (tick && (goal_left ^ goal_right)) begin
          run_d = 1'b0;
          cnt_d = PF;
          if (goal_right) begin
            p1_d = p1_inc;
`ifndef GAME_SEQ_ALT_SERVE_EN
            sdir_d = 1'b1;
`endif
            if (p1_inc == WIN) begin
              state_d = OVER;
              win_d   = 3'd1;
            end else state_d = POINT;
          end else begin
            p2_d = p2_inc;
`ifndef GAME_SEQ_ALT_SERVE_EN
            sdir_d = 1'b0;
`endif
            if (p2_inc == WIN) begin
              state_d = OVER;
              win_d   = 3'd2;
            end else state_d = POINT;
          end
        end
      end
      POINT: begin
        if (tick) begin
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          else begin
            state_d = SERVE;
            load_d  = 1'b1;
            cnt_d   = SF;
`ifdef GAME_SEQ_ALT_SERVE_EN
            sdir_d  = ~sdir_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ball_run  = run_q;
  assign ball_load = load_q;
  assign serve_dir = sdir_q;
  assign score_p1  = p1_q;
  assign score_p2  = p2_q;
  assign winner    = win_q;
  assign state     = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer (WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=3).
module tb_game_sequencer;
  logic       clk = 1'b0, reset = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0, goal_left = 1'b0, goal_right = 1'b0;
  logic       ball_run, ball_load, serve_dir;
  logic [3:0] score_p1, score_p2;
  logic [2:0] winner, state;

  game_sequencer #(.WIN_SCORE(3), .SERVE_FRAMES(2), .POINT_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .goal_left(goal_left), .goal_right(goal_right), .ball_run(ball_run),
    .ball_load(ball_load), .serve_dir(serve_dir), .score_p1(score_p1),
    .score_p2(score_p2), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int st, p1, p2, win, run, load, sd;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  int e_st = 0, e_p1 = 0, e_p2 = 0, e_win = 0, e_run = 0, e_sd = 0;
  string cur_tag = "rst";

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic ld);
    exp_t e;
    e.tag = cur_tag; e.st = e_st; e.p1 = e_p1; e.p2 = e_p2; e.win = e_win;
    e.run = e_run; e.load = int'(ld); e.sd = e_sd;
    q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (q.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = q.pop_front();
    chk({e.tag, ".state"}, int'(state), e.st);
    chk({e.tag, ".p1"}, int'(score_p1), e.p1);
    chk({e.tag, ".p2"}, int'(score_p2), e.p2);
    chk({e.tag, ".winner"}, int'(winner), e.win);
    chk({e.tag, ".run"}, int'(ball_run), e.run);
    chk({e.tag, ".load"}, int'(ball_load), e.load);
    chk({e.tag, ".sdir"}, int'(serve_dir), e.sd);
  endtask

  // One clock: expectation queued, then compared 1ns after the edge.
  task automatic cyc(input logic ld);
    push(ld);
    @(posedge clk); #1;
    sb_check();
  endtask

  // A frame_tick level held two cycles must act as a single event.
  task automatic tick(input logic ld);
    frame_tick = 1'b1; cyc(ld); cyc(1'b0);
    frame_tick = 1'b0; cyc(1'b0);
  endtask

  task automatic new_game();
    cur_tag = "start";
    start = 1'b1;
    e_st = 1; e_p1 = 0; e_p2 = 0; e_win = 0; e_run = 0; e_sd = 0;
    cyc(1'b1); cyc(1'b0);
    start = 1'b0; cyc(1'b0);
  endtask

  task automatic serve_to_play();
    cur_tag = "serve";
    tick(1'b0); tick(1'b0);
    e_st = 2; e_run = 1; cur_tag = "to_play";
    tick(1'b0);
  endtask

  task automatic point_to_serve();
    cur_tag = "point";
    tick(1'b0); tick(1'b0); tick(1'b0);
    e_st = 1; cur_tag = "reserve";
`ifdef GAME_SEQ_ALT_SERVE_EN
    e_sd = 1 - e_sd;
`endif
    tick(1'b1);
  endtask

  task automatic score_right();
    cur_tag = "goal_r";
    goal_right = 1'b1;
    e_p1 = e_p1 + 1; e_run = 0;
`ifndef GAME_SEQ_ALT_SERVE_EN
    e_sd = 1;
`endif
    if (e_p1 == 3) begin e_st = 4; e_win = 1; end else e_st = 3;
    tick(1'b0);
  endtask

  task automatic score_left();
    cur_tag = "goal_l";
    goal_left = 1'b1;
    e_p2 = e_p2 + 1; e_run = 0;
`ifndef GAME_SEQ_ALT_SERVE_EN
    e_sd = 0;
`endif
    if (e_p2 == 3) begin e_st = 4; e_win = 2; end else e_st = 3;
    tick(1'b0);
    goal_left = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 push(1'b0); sb_check();                 // async reset values
    start = 1'b1; cyc(1'b0); start = 1'b0;     // start ignored under reset
    cyc(1'b0);
    reset = 1'b1;
    cur_tag = "idle"; cyc(1'b0);
    tick(1'b0);                                // tick in IDLE does nothing

    new_game();
    cur_tag = "serve_start";                   // start_p ignored in SERVE
    start = 1'b1; cyc(1'b0); start = 1'b0; cyc(1'b0);
    serve_to_play();

    // goal_right held across three ticks scores exactly once
    score_right();
    cur_tag = "held"; tick(1'b0); tick(1'b0);
    goal_right = 1'b0;
    cur_tag = "point"; tick(1'b0);
    e_st = 1; cur_tag = "reserve1";
`ifdef GAME_SEQ_ALT_SERVE_EN
    e_sd = 1 - e_sd;
`endif
    tick(1'b1);                                // POINT_FRAMES+1 = 4 ticks
    serve_to_play();

    // simultaneous goals: no score, stays in PLAY
    cur_tag = "both";
    goal_left = 1'b1; goal_right = 1'b1; tick(1'b0);
    goal_left = 1'b0; goal_right = 1'b0;

    score_right(); goal_right = 1'b0;
    point_to_serve();                          // serve_dir second re-serve
    serve_to_play();

    // async reset mid-PLAY with score_p1 = 2
    cur_tag = "midrst";
    #2 reset = 1'b0; start = 1'b1;
    #1 e_st = 0; e_p1 = 0; e_p2 = 0; e_win = 0; e_run = 0; e_sd = 0;
    push(1'b0); sb_check();
    @(negedge clk);
    cyc(1'b0); cyc(1'b0);
    start = 1'b0; cyc(1'b0);
    reset = 1'b1; cyc(1'b0);

    // player 2 wins 3-0
    new_game();
    serve_to_play(); score_left(); point_to_serve();
    serve_to_play(); score_left(); point_to_serve();
    serve_to_play(); score_left();
    cur_tag = "over"; tick(1'b0);              // OVER holds

    // start and tick together in OVER: start wins
    cur_tag = "restart";
    start = 1'b1; frame_tick = 1'b1;
    e_st = 1; e_p1 = 0; e_p2 = 0; e_win = 0; e_run = 0; e_sd = 0;
    cyc(1'b1);
    start = 1'b0; frame_tick = 1'b0; cyc(1'b0);
    cur_tag = "serve_after"; tick(1'b0);       // counter reloaded to 2

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, meaning the points that end a game (legal 1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, meaning the frames the ball is held before release (legal 0..255).
REQ-003 SHALL have parameter POINT_FRAMES, default 90, meaning the frames of pause after a point (legal 0..255).
REQ-004 SHALL have port clk, input, 1 bit: system clock; the only clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port frame_tick, input, 1 bit: end-of-frame level, synchronous to clk, possibly multi-cycle.
REQ-007 SHALL have port start, input, 1 bit: player start button, synchronous level.
REQ-008 SHALL have port goal_left, input, 1 bit: ball overlaps left win segment (player 2 scores).
REQ-009 SHALL have port goal_right, input, 1 bit: ball overlaps right win segment (player 1 scores).
REQ-010 SHALL have port ball_run, output, 1 bit: enables ball motion datapath.
REQ-011 SHALL have port ball_load, output, 1 bit: one-cycle pulse reloading ball to init x/y.
REQ-012 SHALL have port serve_dir, output, 1 bit: 0 = serve toward player 1 (left), 1 = toward player 2.
REQ-013 SHALL have ports score_p1 and score_p2, output, 4 bits each: current scores.
REQ-014 SHALL have port winner, output, 3 bits: 0 none, 1 player 1, 2 player 2; feeds segment decoder.
REQ-015 SHALL have port state, output, 3 bits: encoded FSM state for debug.

Function
REQ-016 SHALL derive tick = frame_tick & ~frame_tick_q and start_p = start & ~start_q; all game events SHALL be qualified by these one-cycle pulses.
REQ-017 SHALL register all outputs; an event SHALL be visible on outputs at the first clk edge where the rising input is sampled high (1-cycle latency).
REQ-018 SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; codes 5..7 SHALL return to IDLE on the next clk.
REQ-019 IDLE: on start_p -> SERVE; clear scores and winner; pulse ball_load; load frame counter with SERVE_FRAMES.
REQ-020 SERVE: on tick with counter != 0, decrement; on tick with counter == 0 -> PLAY, ball_run=1.
REQ-021 PLAY: goal inputs SHALL be sampled only on tick; goal_right -> score_p1+1, goal_left -> score_p2+1.
REQ-022 PLAY: if goal_left and goal_right are both high on the same tick, no score SHALL be awarded and the state SHALL remain PLAY.
REQ-023 On a score, ball_run SHALL drop the same cycle; if the new score equals WIN_SCORE -> OVER with winner set, else -> POINT with counter = POINT_FRAMES.
REQ-024 POINT: count down on ticks; on tick with counter == 0 -> SERVE, pulse ball_load, counter = SERVE_FRAMES.
REQ-025 OVER: hold scores and winner; on start_p -> SERVE exactly as from IDLE.
REQ-026 start_p in SERVE, PLAY or POINT SHALL be ignored.
REQ-027 Scores SHALL saturate at 15; the counter SHALL be 8 bits and never wrap below 0.
REQ-028 If tick and start_p coincide in IDLE/OVER, start_p SHALL win; the tick SHALL be discarded.

Reset
REQ-029 While reset=0: state=IDLE, ball_run=0, ball_load=0, serve_dir=0, scores=0, winner=0, counter=0, edge registers=0, independent of clk.
REQ-030 Reset asserted mid-game SHALL abort immediately; after release the block SHALL wait in IDLE for start_p.

Configuration
REQ-031 With GAME_SEQ_ALT_SERVE_EN defined, serve_dir SHALL toggle on every entry to SERVE from POINT and reset to 0 on new game.
REQ-032 Without GAME_SEQ_ALT_SERVE_EN, serve_dir SHALL be set on each score toward the player who conceded (goal_left -> 0, goal_right -> 1) and be 0 on new game.

Verification
REQ-033 Reset, start pulse, SERVE_FRAMES=2 -> ball_load for 1 cycle, state=1, ball_run rises on the 3rd tick, state=2.
REQ-034 In PLAY, goal_right held for 3 ticks -> score_p1=1 exactly (counting stops once PLAY exits), state=3, ball_run=0; after POINT_FRAMES+1 ticks -> state=1 with ball_load pulse.
REQ-035 WIN_SCORE=3, three goal_left points -> score_p2=3, winner=2, state=4; start pulse -> scores 0, winner 0, state=1.
REQ-036 goal_left and goal_right high on the same tick in PLAY -> scores unchanged, state=2.
REQ-037 reset low mid-PLAY with score_p1=2 -> all outputs at reset values asynchronously; start ignored until reset high.
REQ-038 Run with and without GAME_SEQ_ALT_SERVE_EN, sequence goal_right, goal_right -> serve_dir 1,0 (alternate) versus 1,1 (conceder).
